// File: rtl/seg7_scan_scheduler_pkg.sv
// seg7_scan_scheduler: shared constants, types and helpers for the display scan scheduler.
package seg7_pkg;

    localparam int DIGITS = 4;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    typedef struct packed {
        logic [1:0] idx;
        logic       wrap;
    } next_t;

    // Circular upward search from idx+1; offset DIGITS lands back on idx, so a lone enabled digit is kept.
    function automatic next_t next_enabled(input logic [1:0] idx, input logic [3:0] mask);
        next_t r;
        r.idx = idx;
        for (int i = DIGITS; i >= 1; i--)
            if (mask[2'(idx + 2'(i))]) r.idx = 2'(idx + 2'(i));
        r.wrap = r.idx <= idx;
        return r;
    endfunction

    function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] k);
        return k != 2'd0 && (v >> {k, 2'b00}) == 16'h0;
    endfunction

endpackage

// File: rtl/seg7_scan_scheduler_if.sv
// seg7_scan_scheduler_if: value/decimal-point update channel with valid/ready handshake.
interface seg7_scan_scheduler_if;

    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        value_valid;
    logic        value_ready;

    modport master (output value_in, dp_in, value_valid, input value_ready);
    modport slave  (input value_in, dp_in, value_valid, output value_ready);

endinterface

// File: rtl/seg7_scan_scheduler_slot_timer.sv
// seg7_slot_timer: free-running slot counter with slot-end flag and next-cycle blank-phase flag.
module seg7_slot_timer #(
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic clk,
    input  logic rst,
    output logic slot_end,
    output logic blank_next
);

    localparam int W = SLOT_CYCLES > 1 ? $clog2(SLOT_CYCLES) : 1;

    logic [W-1:0] cnt, cnt_next;

    assign slot_end   = cnt == W'(SLOT_CYCLES - 1);
    assign cnt_next   = slot_end ? '0 : cnt + 1'b1;
    // Outputs are registered, so the phase is judged on the count the next cycle will hold.
    assign blank_next = int'(cnt_next) < BLANK_CYCLES;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else     cnt <= cnt_next;

endmodule

// File: rtl/seg7_scan_scheduler.sv
// seg7_scan_scheduler: 4-digit multiplexed display scan with blanking gap, zero suppression
// and frame-synchronous value update.
module seg7_scan_scheduler
    import seg7_pkg::*;
#(
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int LZ_SUPPRESS  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    seg7_scan_scheduler_if.slave        bus,
    input  logic [3:0]                  digit_en,
    output logic [3:0]                  bcd_out,
    output logic                        dp_out,
    output logic [3:0]                  sel_an,
    output logic [1:0]                  digit_idx,
    output logic                        frame_done
);

    logic        slot_end, blank_next;
    logic [15:0] active, pending, active_next;
    logic [3:0]  act_dp, pend_dp, act_dp_next;
    logic        pending_full;
    next_t       nx;
    logic [1:0]  idx_next;
    logic        boundary, load, take, visible;

    seg7_slot_timer #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .slot_end  (slot_end),
        .blank_next(blank_next)
    );

    assign bus.value_ready = ~pending_full;

    always_comb begin
        nx          = next_enabled(digit_idx, digit_en);
        idx_next    = slot_end ? nx.idx : digit_idx;
        boundary    = slot_end && nx.wrap;
        load        = boundary && pending_full;
        take        = bus.value_valid && !pending_full;
        active_next = load ? pending : active;
        act_dp_next = load ? pend_dp : act_dp;
        visible     = digit_en[idx_next] && !(LZ_SUPPRESS != 0 && lz_blank(active_next, idx_next));
    end

    // Display outputs are derived from next-state values so they move together with digit_idx.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            digit_idx    <= 2'd0;
            frame_done   <= 1'b0;
            active       <= '0;
            act_dp       <= '0;
            pending      <= '0;
            pend_dp      <= '0;
            pending_full <= 1'b0;
            bcd_out      <= '0;
            dp_out       <= 1'b0;
            sel_an       <= ANODE_OFF;
        end else begin
            digit_idx    <= idx_next;
            frame_done   <= boundary;
            active       <= active_next;
            act_dp       <= act_dp_next;
            pending_full <= take | (pending_full & ~load);
            if (take) begin
                pending <= bus.value_in;
                pend_dp <= bus.dp_in;
            end
            bcd_out      <= active_next[{idx_next, 2'b00} +: 4];
            dp_out       <= act_dp_next[idx_next];
            sel_an       <= (blank_next || !visible) ? ANODE_OFF : ~(4'b0001 << idx_next);
        end

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// tb_seg7_scan_scheduler: table vectors, corner sequences and random traffic for two
// scheduler instances (without and with leading-zero suppression) against a cycle model.
module tb_seg7_scan_scheduler;

    localparam int S = 8;
    localparam int B = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [3:0] digit_en;
    logic [3:0] bcd0, sel0, bcd1, sel1;
    logic [1:0] idx0, idx1;
    logic dp0, dp1, fd0, fd1;
    int checks = 0;
    int errors = 0;

    seg7_scan_scheduler_if bif0 ();
    seg7_scan_scheduler_if bif1 ();

    seg7_scan_scheduler #(.SLOT_CYCLES(S), .BLANK_CYCLES(B), .LZ_SUPPRESS(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bif0), .digit_en(digit_en), .bcd_out(bcd0),
        .dp_out(dp0), .sel_an(sel0), .digit_idx(idx0), .frame_done(fd0));

    seg7_scan_scheduler #(.SLOT_CYCLES(S), .BLANK_CYCLES(B), .LZ_SUPPRESS(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bif1), .digit_en(digit_en), .bcd_out(bcd1),
        .dp_out(dp1), .sel_an(sel1), .digit_idx(idx1), .frame_done(fd1));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          cnt;
        int          idx;
        logic [15:0] act;
        logic [3:0]  adp;
        bit          pfull;
        logic [15:0] pv;
        logic [3:0]  pdp;
        logic [3:0]  sel;
        logic [3:0]  bcd;
        logic        dp;
        logic        fd;
    } mstate_t;

    mstate_t m0, m1;

    function automatic mstate_t mreset();
        mstate_t r;
        r.cnt = 0; r.idx = 0; r.act = '0; r.adp = '0; r.pfull = 0;
        r.pv = '0; r.pdp = '0; r.sel = 4'hF; r.bcd = '0; r.dp = 0; r.fd = 0;
        return r;
    endfunction

    // Slot position as an integer, next digit found by scanning offsets 1..4 of the mask.
    function automatic mstate_t mstep(mstate_t s, bit lz, logic v, logic [15:0] val,
                                      logic [3:0] dpi, logic [3:0] en);
        mstate_t n = s;
        bit found = 0;
        logic [15:0] upper;
        n.fd = 0;
        if (s.cnt == S - 1) begin
            n.cnt = 0;
            for (int k = 1; k <= 4; k++)
                if (!found && en[(s.idx + k) % 4]) begin
                    n.idx = (s.idx + k) % 4;
                    found = 1;
                end
            if (n.idx <= s.idx) begin
                n.fd = 1;
                if (s.pfull) begin
                    n.act = s.pv; n.adp = s.pdp; n.pfull = 0;
                end
            end
        end else begin
            n.cnt = s.cnt + 1;
        end
        if (v && !s.pfull) begin
            n.pv = val; n.pdp = dpi; n.pfull = 1;
        end
        upper = n.act >> (4 * n.idx);
        n.bcd = upper[3:0];
        n.dp  = n.adp[n.idx];
        n.sel = (n.cnt < B || !en[n.idx] || (lz && n.idx > 0 && upper == 16'h0))
                ? 4'hF : ~(4'b0001 << n.idx);
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] val, input logic [3:0] dpi);
        bif0.value_valid = v;  bif1.value_valid = v;
        bif0.value_in    = val; bif1.value_in   = val;
        bif0.dp_in       = dpi; bif1.dp_in      = dpi;
    endtask

    task automatic compare_all();
        chk("m0_sel", sel0, m0.sel);   chk("m1_sel", sel1, m1.sel);
        chk("m0_bcd", bcd0, m0.bcd);   chk("m1_bcd", bcd1, m1.bcd);
        chk("m0_dp", dp0, m0.dp);      chk("m1_dp", dp1, m1.dp);
        chk("m0_idx", idx0, m0.idx);   chk("m1_idx", idx1, m1.idx);
        chk("m0_fd", fd0, m0.fd);      chk("m1_fd", fd1, m1.fd);
        chk("m0_ready", bif0.value_ready, !m0.pfull);
        chk("m1_ready", bif1.value_ready, !m1.pfull);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (!rst) begin
            m0 = mstep(m0, 0, bif0.value_valid, bif0.value_in, bif0.dp_in, digit_en);
            m1 = mstep(m1, 1, bif1.value_valid, bif1.value_in, bif1.dp_in, digit_en);
            compare_all();
        end
    endtask

    task automatic wait_fd(input string name);
        bit got = 0;
        for (int c = 0; c < 48 && !got; c++) begin
            cycle();
            got = fd0;
        end
        chk(name, got, 1);
    endtask

    task automatic reset_checks(input string name);
        chk({name, "_sel0"}, sel0, 4'hF);  chk({name, "_sel1"}, sel1, 4'hF);
        chk({name, "_idx0"}, idx0, 0);     chk({name, "_idx1"}, idx1, 0);
        chk({name, "_fd0"}, fd0, 0);       chk({name, "_fd1"}, fd1, 0);
        chk({name, "_bcd0"}, bcd0, 0);     chk({name, "_dp0"}, dp0, 0);
        chk({name, "_rdy0"}, bif0.value_ready, 1);
        chk({name, "_rdy1"}, bif1.value_ready, 1);
    endtask

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dpi;
        logic [15:0] sel0;
        logic [15:0] sel1;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{16'h1234, 4'b0010, 16'h7BDE, 16'h7BDE};
        vecs[1] = '{16'h0042, 4'b0001, 16'h7BDE, 16'hFFDE};
        vecs[2] = '{16'h0000, 4'b1000, 16'h7BDE, 16'hFFFE};
        vecs[3] = '{16'h0905, 4'b0100, 16'h7BDE, 16'hFBDE};
        vecs[4] = '{16'h8000, 4'b1111, 16'h7BDE, 16'h7BDE};
        vecs[5] = '{16'h0100, 4'b0000, 16'h7BDE, 16'hFBDE};
        digit_en = 4'hF;
        drive(0, '0, '0);
        m0 = mreset();
        m1 = mreset();
        #2 rst = 1'b1;
        #1 reset_checks("por");
        @(negedge clk);
        rst = 1'b0;

        // Table: load each value, sync to the frame that shows it, check every slot.
        for (int i = 0; i < 6; i++) begin
            logic [15:0] v, s0, s1;
            logic [3:0] d;
            v = vecs[i].val; d = vecs[i].dpi; s0 = vecs[i].sel0; s1 = vecs[i].sel1;
            digit_en = 4'hF;
            drive(1, v, d);
            cycle();
            chk("tbl_accept", bif0.value_ready, 0);
            drive(0, '0, '0);
            wait_fd("tbl_fd");
            for (int j = 0; j < 32; j++) begin
                int k;
                if (j > 0) cycle();
                k = j / 8;
                if (j % 8 == 0) begin
                    chk("tbl_idx", idx0, k);
                    chk("tbl_bcd0", bcd0, v[4*k +: 4]);
                    chk("tbl_bcd1", bcd1, v[4*k +: 4]);
                    chk("tbl_dp", dp0, d[k]);
                    if (j > 0) chk("tbl_no_fd", fd0, 0);
                end
                if (j % 8 == 1) chk("tbl_blank", sel0, 4'hF);
                if (j % 8 == 5) begin
                    chk("tbl_sel0", sel0, s0[4*k +: 4]);
                    chk("tbl_sel1", sel1, s1[4*k +: 4]);
                end
            end
        end

        // Handshake: a second offer is held off until the frame that publishes the first.
        drive(1, 16'h1111, 4'h0);
        cycle();
        drive(0, '0, '0);
        wait_fd("hs_load1");
        chk("hs_show1", bcd0, 4'h1);
        repeat (10) cycle();
        drive(1, 16'h2222, 4'h0);
        cycle();
        chk("hs_ack2", bif0.value_ready, 0);
        drive(1, 16'h3333, 4'h0);
        for (int c = 0; c < 48 && !fd0; c++) begin
            cycle();
            if (!fd0) begin
                chk("hs_hold_ready", bif0.value_ready, 0);
                chk("hs_hold_bcd", bcd0, 4'h1);
            end
        end
        chk("hs_boundary", fd0, 1);
        chk("hs_show2", bcd0, 4'h2);
        chk("hs_ready_free", bif0.value_ready, 1);
        cycle();
        chk("hs_ack3", bif0.value_ready, 0);
        drive(0, '0, '0);
        wait_fd("hs_load3");
        chk("hs_show3", bcd0, 4'h3);

        // Mask 0101: digits 0 and 2 only, two-slot frames.
        digit_en = 4'b0101;
        wait_fd("mask_sync");
        chk("mask_idx0", idx0, 0);
        begin
            int gap = 0;
            do begin
                cycle();
                gap++;
                if (gap == 8) chk("mask_idx2", idx0, 2);
            end while (!fd0 && gap < 40);
            chk("mask_gap", gap, 16);
        end

        // Empty mask: anodes dark, boundary every slot.
        digit_en = 4'b0000;
        wait_fd("empty_sync");
        begin
            int gap = 0;
            do begin
                cycle();
                gap++;
                chk("empty_sel", sel0, 4'hF);
            end while (!fd0 && gap < 40);
            chk("empty_gap", gap, 8);
        end

        // Mid-slot disable of the current digit; next digit comes from the new mask.
        digit_en = 4'hF;
        for (int c = 0; c < 80 && !(m0.cnt == 4 && m0.idx == 1); c++) cycle();
        chk("dis_sync", idx0, 1);
        chk("dis_show", sel0, 4'hD);
        digit_en = 4'b1001;
        cycle();
        chk("dis_blank", sel0, 4'hF);
        begin
            int n = 1;
            while (idx0 == 2'd1 && n < 20) begin
                cycle();
                n++;
            end
            chk("dis_len", n, 4);
            chk("dis_next", idx0, 3);
        end

        // Asynchronous reset between edges drops pending and active contents.
        digit_en = 4'hF;
        drive(1, 16'h5555, 4'hF);
        cycle();
        drive(0, '0, '0);
        repeat (3) cycle();
        #3 rst = 1'b1;
        #1 reset_checks("arst");
        @(negedge clk);
        rst = 1'b0;
        m0 = mreset();
        m1 = mreset();
        wait_fd("arst_frame");
        chk("arst_lost", bcd0, 4'h0);

        // Random traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 39) == 0)
                digit_en = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            drive($urandom_range(0, 2) == 0, 16'($urandom), 4'($urandom));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
